// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared definitions for the two-road traffic phase sequencer.
// Holds the phase codes, the lamp patterns for each phase and small helpers
// that map a phase to its lamps and to its successor. The RTL and the
// bench both use these definitions.
package traffic_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    PH_G0   = 2'd0,
    PH_CLR0 = 2'd1,
    PH_G1   = 2'd2,
    PH_CLR1 = 2'd3
  } phase_e;

  // Lamp patterns. Bit i of each pair belongs to road i.
  localparam logic [1:0] R_G0  = 2'b10;
  localparam logic [1:0] G_G0  = 2'b01;
  localparam logic [1:0] R_CLR = 2'b11;
  localparam logic [1:0] G_CLR = 2'b00;
  localparam logic [1:0] R_G1  = 2'b01;
  localparam logic [1:0] G_G1  = 2'b10;

  function automatic logic [1:0] red_for(input phase_e p);
    logic [1:0] r;
    r = R_CLR;
    case (p)
      PH_G0:   r = R_G0;
      PH_G1:   r = R_G1;
      default: r = R_CLR;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] green_for(input phase_e p);
    logic [1:0] g;
    g = G_CLR;
    case (p)
      PH_G0:   g = G_G0;
      PH_G1:   g = G_G1;
      default: g = G_CLR;
    endcase
    return g;
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    n = PH_G0;
    case (p)
      PH_G0:   n = PH_CLR0;
      PH_CLR0: n = PH_G1;
      PH_G1:   n = PH_CLR1;
      default: n = PH_G0;
    endcase
    return n;
  endfunction

  function automatic logic is_green(input phase_e p);
    return (p == PH_G0) || (p == PH_G1);
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_btn_sync_edge.sv
// Demand-button conditioning: two-flop synchroniser followed by a
// rising-edge detector producing a one-cycle pulse.
// Ports:
//   clk       in  system clock
//   reset     in  synchronous, active-high
//   btn_async in  raw asynchronous button level
//   btn_rise  out one-cycle pulse on a synchronised 0->1 transition
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_async,
  output logic btn_rise
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       hist_q,  hist_d;
  logic [1:0] fill_q,  fill_d;

  // The history flop resets high and keeps reading high until sync2 holds a
  // genuine sample of the button (fill_q[1]). A button held down across
  // reset therefore never looks like a fresh press.
  always_comb begin
    sync1_d  = btn_async;
    sync2_d  = sync1_q;
    fill_d   = {fill_q[0], 1'b1};
    hist_d   = fill_q[1] ? sync2_q : 1'b1;
    btn_rise = sync2_q & ~hist_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b1;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road traffic-light sequencer.
// Cycles G0 -> CLR0 -> G1 -> CLR1 on the divider tick, with a countdown for
// the display and a demand button that truncates the current green.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high
//   tick   in  one-cycle enable; all timing advances only when high
//   btn    in  asynchronous demand button (level, active-high)
//   R      out red lamp per road (bit i = road i), registered
//   G      out green lamp per road (bit i = road i), registered
//   count  out remaining ticks in the current phase
//   phase  out current phase code (also serves as FSM state visibility)
module traffic_phase_sequencer
  import traffic_phase_sequencer_pkg::*;
#(
  parameter int GREEN_T = 5,
  parameter int CLR_T   = 2,
  parameter int SHORT_T = 1,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          btn,
  output logic [1:0]    R,
  output logic [1:0]    G,
  output logic [CW-1:0] count,
  output logic [1:0]    phase
);

  if (GREEN_T < 1 || GREEN_T > (1 << CW)) begin : g_bad_green
    $error("GREEN_T must lie in 1..2^CW");
  end
  if (CLR_T < 1 || CLR_T > (1 << CW)) begin : g_bad_clr
    $error("CLR_T must lie in 1..2^CW");
  end
  if (SHORT_T < 0 || SHORT_T >= GREEN_T - 1) begin : g_bad_short
    $error("SHORT_T must be below GREEN_T-1");
  end

  localparam logic [CW-1:0] GREEN_LOAD = CW'(GREEN_T - 1);
  localparam logic [CW-1:0] CLR_LOAD   = CW'(CLR_T - 1);
  localparam logic [CW-1:0] SHORT_LOAD = CW'(SHORT_T);
  localparam logic [CW-1:0] ONE        = CW'(1);

  phase_e        phase_q, phase_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    r_q, r_d;
  logic [1:0]    g_q, g_d;
  logic          req_q, req_d;
  logic          btn_rise;

  btn_sync_edge u_btn (
    .clk       (clk),
    .reset     (reset),
    .btn_async (btn),
    .btn_rise  (btn_rise)
  );

  always_comb begin
    phase_d = phase_q;
    count_d = count_q;
    req_d   = req_q;
    if (tick) begin
      if (count_q == '0) begin
        phase_d = next_phase(phase_q);
        count_d = is_green(phase_q) ? CLR_LOAD : GREEN_LOAD;
        // A request that could not shorten this green is spent with it;
        // one raised during clearance survives into the next green.
        if (is_green(phase_q)) req_d = 1'b0;
      end else if (is_green(phase_q) && req_q && (count_q > SHORT_LOAD)) begin
        count_d = SHORT_LOAD;
        req_d   = 1'b0;
      end else begin
        count_d = count_q - ONE;
      end
    end
    // The edge lands in req at this clock edge, so a tick in the detection
    // cycle still sees the old req. A fresh press outranks a same-cycle clear.
    if (btn_rise) req_d = 1'b1;
    // Lamps are registered from the next phase so they change with it.
    r_d = red_for(phase_d);
    g_d = green_for(phase_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_G0;
      count_q <= GREEN_LOAD;
      r_q     <= R_G0;
      g_q     <= G_G0;
      req_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
      r_q     <= r_d;
      g_q     <= g_d;
      req_q   <= req_d;
    end
  end

  assign R     = r_q;
  assign G     = g_q;
  assign count = count_q;
  assign phase = phase_q;

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Two-road traffic-light sequencer driving the R/G lamp outputs and the 3-bit countdown value that feeds the seven-segment decoder.
- Advances through green and all-red clearance phases on a slow tick enable from the frequency divider.
- Single clock domain, so no divided clock is used.
- A pedestrian/demand button shortens the current green.

Parameters:
GREEN_T, 5, green duration in ticks (1..2^CW)
CLR_T, 2, all-red clearance duration in ticks (1..2^CW)
SHORT_T, 1, remaining count loaded when a button request truncates green (< GREEN_T-1)
CW, 3, countdown width

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
tick  in  1  one-cycle enable pulse from the divider; all timing advances only on tick=1
btn  in  1  asynchronous, level, active-high demand button
R  out  2  red lamp per road; bit i = road i
G  out  2  green lamp per road; bit i = road i
count  out  CW  remaining ticks in current phase, for display
phase  out  2  current phase code

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: phase=G0, count=GREEN_T-1, R=2'b10, G=2'b01, req=0, sync flops=0.
  - Reset asserted mid-operation wins over tick and btn in the same cycle.
- Phases: G0 -> CLR0 -> G1 -> CLR1 -> G0.
  - G0: R=10, G=01. CLR0: R=11, G=00. G1: R=01, G=10. CLR1: R=11, G=00.
  - All outputs are registered and change only on clk edges.
- Countdown:
  - Each phase loads its duration minus 1 on entry.
  - On a tick with count!=0: count decrements by 1.
  - On a tick with count==0: advance phase and load the next phase's duration minus 1 in the same edge.
  - Each phase therefore lasts exactly its duration in ticks; a full cycle is 2*(GREEN_T+CLR_T) ticks (14 at defaults).
  - No tick: count and phase hold.
- Button path:
  - 2-flop synchroniser followed by a rising-edge detector.
  - An edge sets req one cycle after detection.
  - A held button produces a single request.
- Shortening:
  - Applies on a tick in G0/G1 with req=1 and count>SHORT_T.
  - Effect: count loads SHORT_T instead of decrementing, and req clears.
  - If req=1 and count<=SHORT_T, normal decrement applies and req clears on green exit.
- Request during CLR: req is held and acts on the first eligible tick of the next green.
- Edge detect and tick in the same cycle: that tick uses the pre-edge req value. The request acts on a later tick.
- Safety invariants, every cycle:
  - R[i]&G[i]==0.
  - G!=2'b11.
  - Every green is preceded by a CLR phase.
- Width rule: count never exceeds 2^CW-1. The elaboration check fails if GREEN_T or CLR_T > 2^CW, or SHORT_T >= GREEN_T-1.

Decomposition:
- Shared package: phase codes (PH_G0=2'd0, PH_CLR0=2'd1, PH_G1=2'd2, PH_CLR1=2'd3) and lamp constants per phase (R/G pairs above). The same constants serve the top-level and the bench.
- One sub-module: btn_sync_edge. It holds the 2-flop synchroniser and rising-edge pulse output, with synchronous active-high reset on clk/reset.
- The FSM, countdown and req latch stay in the parent.

Test Plan:
- Reset check: hold reset 2 cycles with btn=1 and tick=1 -> phase=0, count=4, R=10, G=01, no request pending after release with btn still high.
- Free-run: tick=1 every cycle, no btn.
  - Required count sequence: 4,3,2,1,0 (G0); 1,0 (CLR0); 4..0 (G1); 1,0 (CLR1); then G0 with count 4 at tick 14.
  - Lamps match the phase at every step.
- Shorten green: tick every 4th cycle; raise btn in G0 at count=4, wait 4 cycles, then tick.
  - Required: count=1, then 0, then CLR0 with count=1.
  - Total G0 = 3 ticks.
- Request in clearance: pulse btn during CLR0, then run ticks.
  - Required: G1 enters with count=4; its first tick loads 1; req=0 afterwards.
  - G0 of the following cycle is not shortened.
- Edge/tick collision and mid-run reset: align the btn edge-detect cycle with a tick in G1 at count=3 -> count=2 (not shortened), next tick -> 1.
  - Then assert reset during CLR1 -> next edge gives G0, count=4, R=10, G=01.
  - Invariants (R&G==0) checked by assertion throughout.
